// File: rtl/frame_seq_pkg.sv
// ---------------------------------------------------------------------------
// frame_seq_pkg
// Shared types and defaults for the frame step sequencer.
//   seq_state_e    : sequencer FSM states
//   frame_t        : one buffered frame {len, wid}
//   DEF_FIFO_DEPTH : default number of buffered frames
//   DEF_POS_W      : default width of the position accumulators
// ---------------------------------------------------------------------------
package frame_seq_pkg;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_POS_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP_L,
        ST_STEP_W
    } seq_state_e;

    typedef struct packed {
        logic [7:0] len;
        logic [7:0] wid;
    } frame_t;

endpackage

// File: rtl/frame_seq_fifo.sv
// ---------------------------------------------------------------------------
// frame_seq_fifo
// Synchronous first-word-fall-through FIFO of frame_t entries.
// A push on a full FIFO is accepted when a pop happens in the same cycle,
// so occupancy stays put and nothing is lost.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push/i_wdata : write strobe and data
//   i_pop          : consume the head entry (ignored when empty)
//   o_rdata        : head entry (valid when !o_empty)
//   o_full/o_empty : occupancy flags, combinational from the count
// ---------------------------------------------------------------------------
module frame_seq_fifo
    import frame_seq_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_push,
    input  frame_t i_wdata,
    input  logic   i_pop,
    output frame_t o_rdata,
    output logic   o_full,
    output logic   o_empty
);

    localparam int AW = $clog2(DEPTH);

    frame_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_cnt;

    logic            w_wr;
    logic            w_rd;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_rdata = r_mem[r_rptr];

    // Full-but-popping still writes: the slot being read frees up this edge.
    assign w_wr = i_push && (!o_full || i_pop);
    assign w_rd = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/frame_step_sequencer.sv
// ---------------------------------------------------------------------------
// frame_step_sequencer
// Receives frames announced by a toggle from an asynchronous SPI domain,
// buffers them, and issues one actuator step per unit of length, then per
// unit of width, accumulating the position on each accepted step.
// Optional build macro:
//   FRAME_SEQ_SAT_EN : positions saturate at all-ones instead of wrapping.
// Ports:
//   CLK, flag            : clock, asynchronous active-low reset
//   frm_tgl              : toggles once per received frame (async)
//   frm_length/frm_width : frame increments, stable around the toggle
//   step_ack             : actuator accepted the current step
//   step_req/step_axis   : step request, axis (0 length, 1 width)
//   pos_length/pos_width : accumulated positions
//   busy                 : FSM not idle
//   fifo_full            : frame buffer full
//   drop_cnt             : frames discarded on a full buffer (saturating)
// ---------------------------------------------------------------------------
module frame_step_sequencer
    import frame_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int POS_W      = DEF_POS_W
) (
    input  logic             CLK,
    input  logic             flag,
    input  logic             frm_tgl,
    input  logic [7:0]       frm_length,
    input  logic [7:0]       frm_width,
    input  logic             step_ack,
    output logic             step_req,
    output logic             step_axis,
    output logic [POS_W-1:0] pos_length,
    output logic [POS_W-1:0] pos_width,
    output logic             busy,
    output logic             fifo_full,
    output logic [7:0]       drop_cnt
);

`ifdef FRAME_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- toggle synchronizer / push strobe ----------------
    logic [1:0] r_sync;
    logic [1:0] r_fill;
    logic       r_ref_vld;
    logic       r_prev;
    logic       r_push;

    // r_fill marks when r_sync[1] carries a real sample; that first sample
    // only becomes the reference so a level held through reset never pushes.
    always_ff @(posedge CLK or negedge flag) begin
        if (!flag) begin
            r_sync    <= '0;
            r_fill    <= '0;
            r_ref_vld <= 1'b0;
            r_prev    <= 1'b0;
            r_push    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], frm_tgl};
            r_fill <= {r_fill[0], 1'b1};
            r_push <= 1'b0;
            if (r_ref_vld) begin
                r_push <= r_sync[1] ^ r_prev;
                r_prev <= r_sync[1];
            end else if (r_fill[1]) begin
                r_prev    <= r_sync[1];
                r_ref_vld <= 1'b1;
            end
        end
    end

    // ---------------- frame FIFO ----------------
    seq_state_e r_state;
    frame_t     w_wdata;
    frame_t     w_rd;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;

    assign w_wdata = '{len: frm_length, wid: frm_width};
    assign w_pop   = (r_state == ST_LOAD);

    frame_seq_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (flag),
        .i_push  (r_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rd),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ---------------- drop counter ----------------
    logic [7:0] r_drop;
    logic       w_drop;

    assign w_drop = r_push && w_full && !w_pop;

    always_ff @(posedge CLK or negedge flag) begin
        if (!flag) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    // ---------------- step FSM ----------------
    logic [7:0]       r_rem_l;
    logic [7:0]       r_rem_w;
    logic             r_req;
    logic             r_axis;
    logic [POS_W-1:0] r_pos_l;
    logic [POS_W-1:0] r_pos_w;
    logic             w_acc;

    assign w_acc = r_req && step_ack;

    always_ff @(posedge CLK or negedge flag) begin
        if (!flag) begin
            r_state <= ST_IDLE;
            r_rem_l <= '0;
            r_rem_w <= '0;
            r_req   <= 1'b0;
            r_axis  <= 1'b0;
            r_pos_l <= '0;
            r_pos_w <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_rem_l <= w_rd.len;
                    r_rem_w <= w_rd.wid;
                    if (w_rd.len != 8'd0) begin
                        r_state <= ST_STEP_L;
                        r_req   <= 1'b1;
                        r_axis  <= 1'b0;
                    end else if (w_rd.wid != 8'd0) begin
                        r_state <= ST_STEP_W;
                        r_req   <= 1'b1;
                        r_axis  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STEP_L: begin
                    if (w_acc) begin
                        r_rem_l <= r_rem_l - 8'd1;
                        if (!(SAT && (&r_pos_l))) r_pos_l <= r_pos_l + 1'b1;
                        if (r_rem_l == 8'd1) begin
                            if (r_rem_w != 8'd0) begin
                                r_state <= ST_STEP_W;
                                r_axis  <= 1'b1;
                            end else begin
                                // end of frame: request drops through LOAD/IDLE
                                r_req   <= 1'b0;
                                r_axis  <= 1'b0;
                                r_state <= w_empty ? ST_IDLE : ST_LOAD;
                            end
                        end
                    end
                end
                ST_STEP_W: begin
                    if (w_acc) begin
                        r_rem_w <= r_rem_w - 8'd1;
                        if (!(SAT && (&r_pos_w))) r_pos_w <= r_pos_w + 1'b1;
                        if (r_rem_w == 8'd1) begin
                            r_req   <= 1'b0;
                            r_axis  <= 1'b0;
                            r_state <= w_empty ? ST_IDLE : ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign step_req   = r_req;
    assign step_axis  = r_axis;
    assign pos_length = r_pos_l;
    assign pos_width  = r_pos_w;
    assign busy       = (r_state != ST_IDLE);
    assign fifo_full  = w_full;
    assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_frame_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_step_sequencer
// Directed bench for frame_step_sequencer (POS_W reduced to 10 so the
// position rollover is reachable in a short run).
// ---------------------------------------------------------------------------
module tb_frame_step_sequencer;

    localparam int PW = 10;

    logic          CLK = 1'b0;
    logic          flag;
    logic          frm_tgl;
    logic [7:0]    frm_length;
    logic [7:0]    frm_width;
    logic          step_ack;
    logic          step_req;
    logic          step_axis;
    logic [PW-1:0] pos_length;
    logic [PW-1:0] pos_width;
    logic          busy;
    logic          fifo_full;
    logic [7:0]    drop_cnt;

    int n_chk = 0;
    int n_err = 0;

    frame_step_sequencer #(
        .FIFO_DEPTH (4),
        .POS_W      (PW)
    ) dut (
        .CLK        (CLK),
        .flag       (flag),
        .frm_tgl    (frm_tgl),
        .frm_length (frm_length),
        .frm_width  (frm_width),
        .step_ack   (step_ack),
        .step_req   (step_req),
        .step_axis  (step_axis),
        .pos_length (pos_length),
        .pos_width  (pos_width),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .drop_cnt   (drop_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] l, input logic [7:0] w);
        frm_length = l;
        frm_width  = w;
        frm_tgl    = ~frm_tgl;
        tick(5);
    endtask

    // Wait (bounded) for a request, note its axis, ack it for one cycle.
    task automatic ack_one(output logic ax);
        int k;
        k = 0;
        while (!step_req && k < 40) begin
            tick();
            k++;
        end
        if (!step_req) chk("ack_wait", {31'd0, step_req}, 32'd1);
        ax       = step_axis;
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
    endtask

    task automatic drain(input int n);
        logic ax;
        for (int i = 0; i < n; i++) ack_one(ax);
    endtask

    initial begin
        logic ax0, ax1, ax2;
        int   req_cnt, busy_cnt;
        logic [PW-1:0] exp_sat;

        flag = 1'b0; frm_tgl = 1'b0; frm_length = '0; frm_width = '0; step_ack = 1'b0;
        tick(3);
        chk("rst_req",  step_req,  1'b0);
        chk("rst_busy", busy,      1'b0);
        chk("rst_posl", pos_length, 0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_drop", drop_cnt,  0);
        flag = 1'b1;
        tick(6);

        // basic frame length=2 width=1
        send_frame(8'd2, 8'd1);
        ack_one(ax0); ack_one(ax1); ack_one(ax2);
        chk("basic_axes", {ax0, ax1, ax2}, 3'b001);
        chk("basic_posl", pos_length, 2);
        chk("basic_posw", pos_width,  1);
        chk("basic_busy", busy,       1'b0);
        chk("basic_req",  step_req,   1'b0);

        // all-zero frame: one LOAD cycle, no request
        frm_length = 8'd0; frm_width = 8'd0; frm_tgl = ~frm_tgl;
        req_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (step_req) req_cnt++;
            if (busy) busy_cnt++;
        end
        chk("zero_req",  req_cnt,    0);
        chk("zero_busy", busy_cnt,   1);
        chk("zero_posl", pos_length, 2);
        chk("zero_posw", pos_width,  1);

        // six frames with ack held low: one active, four buffered, one dropped
        for (int i = 0; i < 6; i++) send_frame(8'd1, 8'd0);
        chk("fill_full", fifo_full, 1'b1);
        chk("fill_drop", drop_cnt,  1);
        chk("fill_req",  step_req,  1'b1);

        // push lands on the same edge as the LOAD pop of a full FIFO
        frm_length = 8'd1; frm_width = 8'd0; frm_tgl = ~frm_tgl;
        tick(2);
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        chk("coin_gap_req", step_req, 1'b0);
        tick();
        chk("coin_drop", drop_cnt,   1);
        chk("coin_full", fifo_full,  1'b1);
        chk("coin_posl", pos_length, 3);
        drain(5);
        chk("drain_posl", pos_length, 8);
        chk("drain_full", fifo_full,  1'b0);
        chk("drain_busy", busy,       1'b0);

        // run the length position up to the top of its range
        send_frame(8'd255, 8'd0);
        send_frame(8'd255, 8'd0);
        send_frame(8'd255, 8'd0);
        send_frame(8'd249, 8'd0);
        drain(1014);
        chk("near_posl", pos_length, 10'h3FE);
        chk("near_drop", drop_cnt,   1);
        send_frame(8'd3, 8'd0);
        drain(3);
`ifdef FRAME_SEQ_SAT_EN
        exp_sat = 10'h3FF;
`else
        exp_sat = 10'h001;
`endif
        chk("ovf_posl", pos_length, exp_sat);
        chk("ovf_posw", pos_width,  1);

        // reset in the middle of a width step
        send_frame(8'd0, 8'd2);
        ack_one(ax0);
        chk("rstw_axis", ax0,       1'b1);
        chk("rstw_posw", pos_width, 2);
        chk("rstw_pre",  step_req,  1'b1);
        flag = 1'b0;
        #1;
        chk("rstw_req",  step_req,   1'b0);
        chk("rstw_ax",   step_axis,  1'b0);
        chk("rstw_busy", busy,       1'b0);
        chk("rstw_posl", pos_length, 0);
        chk("rstw_posw", pos_width,  0);
        chk("rstw_drop", drop_cnt,   0);
        tick();
        flag = 1'b1;
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_req || busy) req_cnt++;
        end
        chk("post_rst_idle", req_cnt, 0);
        send_frame(8'd1, 8'd0);
        ack_one(ax0);
        chk("post_rst_ax",   ax0,        1'b0);
        chk("post_rst_posl", pos_length, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
